// File: rtl/dir_cmd_gen.sv
// -----------------------------------------------------------------------------
// dir_cmd_gen
//
// Turns the four debounced direction-button levels into Pac-Man direction
// commands. Each press edge produces one command. Optional hold-to-repeat
// produces further commands while the button stays down. Commands are queued
// in a 2-entry FIFO and offered to the movement controller over a valid/ready
// handshake.
//
// Optional feature: define DIR_CMD_REPEAT_EN to build the hold-to-repeat
// state machine (DELAY/REPEAT states, timer, tracked direction). When it is
// not defined, only press commands are generated and cmd_repeat is always 0.
//
// Ports
//   clk_i       in   system clock
//   reset       in   asynchronous reset, active low
//   btn_up      in   debounced level, 1 = pressed
//   btn_down    in   debounced level, 1 = pressed
//   btn_left    in   debounced level, 1 = pressed
//   btn_right   in   debounced level, 1 = pressed
//   cmd_ready   in   consumer accepts the head entry when cmd_valid is high
//   cmd_valid   out  FIFO head is valid
//   cmd_dir     out  head direction: 00 up, 01 down, 10 left, 11 right
//   cmd_repeat  out  head is an auto-repeat (1) or a press (0)
//   cmd_drop    out  one-cycle pulse after an event was discarded (FIFO full)
// -----------------------------------------------------------------------------
module dir_cmd_gen #(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int CNT_W         = 25
) (
    input  logic       clk_i,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_dir,
    output logic       cmd_repeat,
    output logic       cmd_drop
);

    // Bit index of each button equals its direction encoding.
    logic [3:0] btn_lvl;
    logic [3:0] btn_q;
    logic [3:0] btn_d;
    logic [3:0] rise;
    logic       press_vld;
    logic [1:0] press_dir;

    // Event offered to the FIFO this cycle: {repeat, dir}
    logic       evt_push;
    logic [2:0] evt_data;

    assign btn_lvl = {btn_right, btn_left, btn_down, btn_up};
    assign btn_d   = btn_lvl;
    assign rise    = btn_lvl & ~btn_q;

    // Only the highest-priority rising button is reported: up > down > left > right.
    always_comb begin
        press_vld = |rise;
        press_dir = 2'd3;
        if (rise[0]) begin
            press_dir = 2'd0;
        end else if (rise[1]) begin
            press_dir = 2'd1;
        end else if (rise[2]) begin
            press_dir = 2'd2;
        end
    end

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            btn_q <= 4'b0000;
        end else begin
            btn_q <= btn_d;
        end
    end

`ifdef DIR_CMD_REPEAT_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       hold_dir_q;
    logic [1:0]       hold_dir_d;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_d;

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            hold_dir_q <= 2'd0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_dir_q <= hold_dir_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_dir_d = hold_dir_q;
        timer_d    = timer_q;
        evt_push   = 1'b0;
        evt_data   = {1'b0, press_dir};

        if (press_vld) begin
            // A new press always retargets, even over a pending repeat expiry.
            evt_push   = 1'b1;
            evt_data   = {1'b0, press_dir};
            hold_dir_d = press_dir;
            timer_d    = DELAY_LOAD;
            state_d    = S_DELAY;
        end else begin
            case (state_q)
                S_DELAY, S_REPEAT: begin
                    if (!btn_lvl[hold_dir_q]) begin
                        state_d = S_IDLE;
                    end else if (timer_q == '0) begin
                        evt_push = 1'b1;
                        evt_data = {1'b1, hold_dir_q};
                        timer_d  = PERIOD_LOAD;
                        state_d  = S_REPEAT;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end
`else
    // Repeat parameters are accepted but have no function in this build.
    logic [31:0] unused_params;
    assign unused_params = 32'(REPEAT_DELAY) ^ 32'(REPEAT_PERIOD) ^ 32'(CNT_W);

    always_comb begin
        evt_push = press_vld;
        evt_data = {1'b0, press_dir};
    end
`endif

    // 2-entry command FIFO
    logic [2:0] mem_q [2];
    logic [2:0] mem_d [2];
    logic       wr_ptr_q;
    logic       wr_ptr_d;
    logic       rd_ptr_q;
    logic       rd_ptr_d;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       drop_q;
    logic       drop_d;
    logic       pop;
    logic       do_push;

    assign pop = (cnt_q != 2'd0) && cmd_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        drop_d   = 1'b0;
        do_push  = 1'b0;

        if (evt_push) begin
            // A full FIFO still accepts a push when the head leaves this edge.
            if ((cnt_q != 2'd2) || pop) begin
                do_push         = 1'b1;
                mem_d[wr_ptr_q] = evt_data;
                wr_ptr_d        = ~wr_ptr_q;
            end else begin
                drop_d = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        cnt_d = cnt_q + {1'b0, do_push} - {1'b0, pop};
    end

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= 3'b000;
            mem_q[1] <= 3'b000;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            drop_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

    assign cmd_valid               = (cnt_q != 2'd0);
    assign {cmd_repeat, cmd_dir}   = mem_q[rd_ptr_q];
    assign cmd_drop                = drop_q;

endmodule

// File: tb/tb_dir_cmd_gen.sv
module tb_dir_cmd_gen;

    logic       clk_i;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic       cmd_repeat;
    logic       cmd_drop;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0;

    int         log_cyc [$];
    logic [2:0] log_ent [$];
    int         exp_c   [4];
    logic [2:0] exp_e   [4];

    dir_cmd_gen #(
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4),
        .CNT_W        (4)
    ) dut (
        .clk_i     (clk_i),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .cmd_repeat(cmd_repeat),
        .cmd_drop  (cmd_drop)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Record every accepted command with the cycle it was visible in.
    always @(negedge clk_i) begin
        if (reset && cmd_valid && cmd_ready) begin
            log_cyc.push_back(cyc);
            log_ent.push_back({cmd_repeat, cmd_dir});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check_log(input string tag, input int n);
        check({tag, "_count"}, 32'(log_cyc.size()), 32'(n));
        for (int i = 0; i < n && i < log_cyc.size(); i++) begin
            check($sformatf("%s_cyc%0d", tag, i), 32'(log_cyc[i] - t0), 32'(exp_c[i]));
            check($sformatf("%s_ent%0d", tag, i), 32'(log_ent[i]), 32'(exp_e[i]));
        end
    endtask

    initial begin
        reset     = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        cmd_ready = 1'b1;
        tick(3);
        check("rst_valid",  32'(cmd_valid),  32'd0);
        check("rst_dir",    32'(cmd_dir),    32'd0);
        check("rst_repeat", 32'(cmd_repeat), 32'd0);
        check("rst_drop",   32'(cmd_drop),   32'd0);
        reset = 1'b1;
        tick(2);
        check("idle_valid", 32'(cmd_valid), 32'd0);

        // Single-cycle left press
        log_cyc.delete(); log_ent.delete();
        t0 = cyc;
        btn_left = 1'b1;
        check("t1_pre_valid", 32'(cmd_valid), 32'd0);
        tick(1);
        check("t1_valid_on", 32'(cmd_valid), 32'd1);
        btn_left = 1'b0;
        tick(1);
        check("t1_valid_off", 32'(cmd_valid), 32'd0);
        tick(3);
        exp_c[0] = 1; exp_e[0] = 3'b010;
        check_log("t1", 1);

        // Hold up for 20 cycles
        log_cyc.delete(); log_ent.delete();
        t0 = cyc;
        btn_up = 1'b1;
        tick(20);
        btn_up = 1'b0;
        tick(6);
        exp_c[0] = 1;  exp_e[0] = 3'b000;
`ifdef DIR_CMD_REPEAT_EN
        exp_c[1] = 9;  exp_e[1] = 3'b100;
        exp_c[2] = 13; exp_e[2] = 3'b100;
        exp_c[3] = 17; exp_e[3] = 3'b100;
        check_log("t2", 4);
`else
        check_log("t2", 1);
`endif

        // Down and right rise together
        log_cyc.delete(); log_ent.delete();
        t0 = cyc;
        btn_down  = 1'b1;
        btn_right = 1'b1;
        tick(3);
        btn_down  = 1'b0;
        btn_right = 1'b0;
        tick(4);
        exp_c[0] = 1; exp_e[0] = 3'b001;
        check_log("t3", 1);

        // FIFO fills, third press dropped, then drained
        log_cyc.delete(); log_ent.delete();
        cmd_ready = 1'b0;
        btn_up = 1'b1;
        tick(1);
        btn_up = 1'b0; btn_down = 1'b1;
        tick(1);
        check("t4_valid", 32'(cmd_valid), 32'd1);
        check("t4_drop_a", 32'(cmd_drop), 32'd0);
        btn_down = 1'b0; btn_left = 1'b1;
        tick(1);
        check("t4_drop_b", 32'(cmd_drop), 32'd1);
        check("t4_head_a", 32'({cmd_repeat, cmd_dir}), 32'd0);
        btn_left = 1'b0;
        tick(1);
        check("t4_drop_c", 32'(cmd_drop), 32'd0);
        tick(2);
        check("t4_drop_d", 32'(cmd_drop), 32'd0);
        check("t4_head_b", 32'({cmd_repeat, cmd_dir}), 32'd0);
        t0 = cyc;
        cmd_ready = 1'b1;
        tick(4);
        check("t4_empty", 32'(cmd_valid), 32'd0);
        exp_c[0] = 0; exp_e[0] = 3'b000;
        exp_c[1] = 1; exp_e[1] = 3'b001;
        check_log("t4", 2);

        // Right press lands on the up repeat-expiry edge
        log_cyc.delete(); log_ent.delete();
        t0 = cyc;
        btn_up = 1'b1;
        tick(8);
        btn_right = 1'b1;
        tick(10);
        btn_up    = 1'b0;
        btn_right = 1'b0;
        tick(6);
        exp_c[0] = 1;  exp_e[0] = 3'b000;
        exp_c[1] = 9;  exp_e[1] = 3'b011;
`ifdef DIR_CMD_REPEAT_EN
        exp_c[2] = 17; exp_e[2] = 3'b111;
        check_log("t5", 3);
`else
        check_log("t5", 2);
`endif

        // Reset while full with left held
        cmd_ready = 1'b0;
        btn_up = 1'b1;
        tick(1);
        btn_up = 1'b0; btn_down = 1'b1;
        tick(1);
        btn_down = 1'b0; btn_left = 1'b1;
        tick(1);
        check("t6_full_valid", 32'(cmd_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(cmd_valid), 32'd0);
        check("t6_rst_drop",  32'(cmd_drop),  32'd0);
        check("t6_rst_head",  32'({cmd_repeat, cmd_dir}), 32'd0);
        tick(2);
        check("t6_rst_hold", 32'(cmd_valid), 32'd0);
        reset = 1'b1;
        log_cyc.delete(); log_ent.delete();
        t0 = cyc;
        cmd_ready = 1'b1;
        tick(3);
        btn_left = 1'b0;
        tick(4);
        exp_c[0] = 1; exp_e[0] = 3'b010;
        check_log("t6", 1);
        check("t6_end_valid", 32'(cmd_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
